// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin encodings and values,
// FSM state encoding and default configuration.
package change_dispenser_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_10   = 2'b10,
        COIN_05   = 2'b11
    } coin_t;

    // Coin values in half-yuan units
    localparam logic [5:0] VAL_05 = 6'd1;
    localparam logic [5:0] VAL_1  = 6'd2;
    localparam logic [5:0] VAL_10 = 6'd20;

    localparam int unsigned SUM_MAX_DEFAULT = 40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE,
        S_FAULT
    } state_t;

    function automatic logic [5:0] coin_value(input coin_t c);
        logic [5:0] v;
        case (c)
            COIN_05: v = VAL_05;
            COIN_1:  v = VAL_1;
            COIN_10: v = VAL_10;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_stock.sv
// coin_stock: 8-bit per-denomination coin counter with reload and a
// decrement that saturates at zero.
module coin_stock #(
    parameter int unsigned INIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= 8'(INIT);
        end else if (dec && (count != '0)) begin
            count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout FSM with ack handshake and timeout fault.
// Define STOCK_TRACK_EN for finite per-coin stocks, reload and short reporting.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned SUM_MAX     = SUM_MAX_DEFAULT,
    parameter int unsigned STOCK_INIT  = 8,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] amount,
    input  logic       eject_ack,
    input  logic       reload,
    output logic       eject_valid,
    output logic [1:0] eject_type,
    output logic [5:0] remain,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic       fault
);

    localparam logic [5:0]  SUM_CAP   = 6'(SUM_MAX);
    localparam int unsigned TW        = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(ACK_TIMEOUT - 1);

    state_t        state;
    coin_t         coin_q;
    coin_t         pick;
    logic [5:0]    remain_q;
    logic [5:0]    amt_cap;
    logic [TW-1:0] wait_cnt;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic          short_q;
    logic          fault_q;
    logic          has_05;
    logic          has_1;
    logic          has_10;

`ifdef STOCK_TRACK_EN
    localparam bit TRACK = 1'b1;

    logic [7:0] stock_05;
    logic [7:0] stock_1;
    logic [7:0] stock_10;
    logic       load_stock;
    logic       ack_take;

    // Reload is only honoured while idle, so it can coincide with an accepted start
    assign load_stock = reload && (state == S_IDLE);
    assign ack_take   = (state == S_EJECT) && eject_ack;

    coin_stock #(.INIT(STOCK_INIT)) u_stock_05 (
        .clk   (clk),
        .rst   (rst),
        .load  (load_stock),
        .dec   (ack_take && (coin_q == COIN_05)),
        .count (stock_05)
    );

    coin_stock #(.INIT(STOCK_INIT)) u_stock_1 (
        .clk   (clk),
        .rst   (rst),
        .load  (load_stock),
        .dec   (ack_take && (coin_q == COIN_1)),
        .count (stock_1)
    );

    coin_stock #(.INIT(STOCK_INIT)) u_stock_10 (
        .clk   (clk),
        .rst   (rst),
        .load  (load_stock),
        .dec   (ack_take && (coin_q == COIN_10)),
        .count (stock_10)
    );

    assign has_05 = (stock_05 != '0);
    assign has_1  = (stock_1  != '0);
    assign has_10 = (stock_10 != '0);
`else
    localparam bit TRACK = 1'b0;

    // Unlimited stocks: reload has no effect
    logic unused_cfg;
    assign unused_cfg = reload | (STOCK_INIT != 0);

    assign has_05 = 1'b1;
    assign has_1  = 1'b1;
    assign has_10 = 1'b1;
`endif

    assign amt_cap = (amount > SUM_CAP) ? SUM_CAP : amount;

    // Largest coin not exceeding the unpaid amount that is still in stock
    always_comb begin
        pick = COIN_NONE;
        if ((remain_q >= VAL_10) && has_10) begin
            pick = COIN_10;
        end else if ((remain_q >= VAL_1) && has_1) begin
            pick = COIN_1;
        end else if ((remain_q >= VAL_05) && has_05) begin
            pick = COIN_05;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            coin_q   <= COIN_NONE;
            remain_q <= '0;
            wait_cnt <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (amount == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            remain_q <= amt_cap;
                            short_q  <= 1'b0;
                            busy_q   <= 1'b1;
                            state    <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (remain_q == '0) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else if (pick == COIN_NONE) begin
                        done_q  <= 1'b1;
                        short_q <= TRACK;
                        state   <= S_DONE;
                    end else begin
                        coin_q   <= pick;
                        valid_q  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_EJECT;
                    end
                end
                S_EJECT: begin
                    if (eject_ack) begin
                        remain_q <= remain_q - coin_value(coin_q);
                        valid_q  <= 1'b0;
                        coin_q   <= COIN_NONE;
                        state    <= S_SELECT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        valid_q <= 1'b0;
                        coin_q  <= COIN_NONE;
                        fault_q <= 1'b1;
                        state   <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign eject_valid = valid_q;
    assign eject_type  = coin_q;
    assign remain      = remain_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign short       = short_q;
    assign fault       = fault_q;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter SUM_MAX, default 40, giving the maximum payout amount in Q1 units (x*2, half-yuan).
REQ-002 SHALL have parameter STOCK_INIT, default 8, giving the per-denomination coin count loaded by reload.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16, giving the number of cycles to wait for eject_ack before faulting.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to pay out amount.
REQ-007 SHALL have port amount, input, 6 bits: payout value in Q1 units, sampled with start.
REQ-008 SHALL have port eject_ack, input, 1 bit: coin mechanism accepted the current coin.
REQ-009 SHALL have port reload, input, 1 bit: one-cycle pulse that refills all coin stocks.
REQ-010 SHALL have port eject_valid, output, 1 bit: a coin request is pending.
REQ-011 SHALL have port eject_type, output, 2 bits: coin denomination, encoded 00 none, 01 1 yuan (2 units), 10 10 yuan (20 units), 11 0.5 yuan (1 unit).
REQ-012 SHALL have port remain, output, 6 bits: unpaid amount in Q1 units.
REQ-013 SHALL have port busy, output, 1 bit: payout in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a payout finishes.
REQ-015 SHALL have port short, output, 1 bit: the last payout ended with remain != 0.
REQ-016 SHALL have port fault, output, 1 bit: ack timeout; sticky until rst.

Function
REQ-017 SHALL implement the states IDLE, SELECT, EJECT, DONE and FAULT.
REQ-018 In IDLE, start with amount=0 SHALL pulse done on the next cycle and remain in IDLE, with no coins ejected.
REQ-019 In IDLE, start with amount>0 SHALL latch min(amount, SUM_MAX) into remain, clear short, and enter SELECT on the next cycle.
REQ-020 SELECT SHALL last 1 cycle and pick the largest coin value <= remain whose stock is > 0; it then enters EJECT with eject_valid=1 and eject_type set.
REQ-021 SELECT with remain=0 SHALL enter DONE; SELECT with no eligible coin SHALL enter DONE with short set.
REQ-022 In EJECT, eject_valid and eject_type SHALL stay stable until eject_ack is high.
REQ-023 On the eject_ack cycle, remain SHALL decrease by the coin value and that stock by 1; the next state is SELECT, and eject_valid is 0 from the next cycle.
REQ-024 Latency SHALL be: start at t gives busy=1 at t+1 and eject_valid=1 at t+2; ack at k gives the next eject_valid at k+2; the final ack at k gives done=1 at k+2.
REQ-025 ACK_TIMEOUT consecutive EJECT cycles without ack SHALL enter FAULT, which sets fault=1, busy=1, eject_valid=0 and accepts no commands until rst.
REQ-026 DONE SHALL last 1 cycle with done=1 and busy=1, then return to IDLE.
REQ-027 start or reload while busy=1 SHALL be ignored.
REQ-028 eject_ack outside EJECT SHALL be ignored.
REQ-029 When reload and start arrive in the same IDLE cycle, both SHALL be accepted; the first SELECT sees the refilled stocks.
REQ-030 Stock counters SHALL be 8 bits and SHALL never decrement below 0.

Reset
REQ-031 rst SHALL set state to IDLE, all stocks to STOCK_INIT, and remain=0, with eject_valid, eject_type, busy, done, short and fault all 0.
REQ-032 rst asserted mid-payout SHALL abandon the payout immediately, with no done pulse.

Configuration
REQ-033 With STOCK_TRACK_EN defined, the block SHALL keep per-denomination stock counters, honour reload, and be able to report short.
REQ-034 Without STOCK_TRACK_EN, stocks SHALL be treated as unlimited, reload ignored, and short tied to 0.

Structure
REQ-035 A shared package SHALL hold: the coin type encodings, the coin values (1, 2, 20), the state encoding, and default SUM_MAX.
REQ-036 Stock counting SHALL be one sub-module, coin_stock, instantiated three times (one per denomination, with load and decrement); it is absent without STOCK_TRACK_EN.

Verification
REQ-037 start with amount=5 and acks returned immediately SHALL produce coins 1, 1 and 0.5 yuan, then done with remain=0 and short=0.
REQ-038 start with amount=40 SHALL produce two 10-yuan coins; stock_10 drops by 2.
REQ-039 Under STOCK_TRACK_EN, with stock_1=0 and stock_05=1, start with amount=3 SHALL eject 0.5 yuan, then done with short=1 and remain=2.
REQ-040 With no ack for 16 cycles, fault SHALL be 1 and a subsequent start SHALL be ignored until rst.
REQ-041 Holding eject_ack low for 5 cycles SHALL keep eject_type stable, and start pulses during that time SHALL have no effect.
REQ-042 rst during the second coin of amount=22 SHALL leave all outputs 0 and remain=0 on the next cycle.
